stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
// - Parametrised N-to-1 datapath multiplexer with valid/ready handshake and one registered output stage.
// - Generalises the fixed 32-bit 2:1/4:1 combinational muxes: width, input count and selection mode are parameters.
// - Selection is either an explicit select input or round-robin arbitration.
// - Sits between multiple producers (e.g. writeback sources, bus requesters) and a single consumer; full throughput of one beat/cycle.
// PARAMETERS
// - WIDTH  32      data width per channel
// - N      4       number of input channels, >=2
// - SEL_W  $clog2(N)  select/channel-index width (derived, do not override)
// - MODE   MUX_SEL  mux_mode_e: MUX_SEL = explicit select, MUX_RR = round-robin
// PORTS
// - clk        in   1          clock, all state on rising edge
// - rst        in   1          synchronous reset, active-high
// - sel        in   SEL_W      channel select, used only when MODE==MUX_SEL
// - in_valid   in   N          per-channel valid
// - in_data    in   N*WIDTH    channel i at bits [i*WIDTH +: WIDTH]
// - in_ready   out  N          per-channel ready (combinational)
// - out_valid  out  1          registered beat available
// - out_data   out  WIDTH      registered data
// - out_ch     out  SEL_W      index of channel that supplied out_data
// - out_ready  in   1          consumer ready
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready=0 while rst=1. Registered beat is dropped.
// - adv = ~out_valid | out_ready (output stage free or draining this cycle).
// - MUX_SEL: grant = one-hot(sel) if sel<N and in_valid[sel], else 0. sel>=N -> no grant, no transfer.
// - MUX_RR: grant = first valid channel scanning rr_ptr, rr_ptr+1, ... mod N. No valid -> no grant.
// - in_ready[i] = adv & grant[i] & ~rst; at most one bit set. in_ready independent of in_valid of other channels only via grant.
// - Transfer on in_valid[i]&in_ready[i]: next cycle out_valid=1, out_data=in_data[i], out_ch=i. Latency 1 cycle.
// - Output handshake: beat consumed on out_valid&out_ready. If consumed and no new transfer -> out_valid=0; out_data/out_ch hold last value.
// - Simultaneous drain+accept: allowed in same cycle, out_valid stays 1, no bubble.
// - Stall (out_valid=1, out_ready=0): out_data/out_ch held stable, in_ready=0 all channels.
// - rr_ptr updates only on a transfer: rr_ptr <= (granted+1) mod N (wrap N-1 -> 0). Unchanged on stall or idle.
// - Producers must hold in_valid/in_data until in_ready; sel may change any cycle, takes effect in that cycle's grant combinationally; an already registered beat is unaffected.
// - No combinational path out_ready -> out_data; out_ready -> in_ready path is permitted.
// STRUCTURE
// - Package amp_mux_pkg: typedef enum logic {MUX_SEL, MUX_RR} mux_mode_e.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr[SEL_W]; outputs gnt[N] one-hot, gnt_idx[SEL_W], gnt_any. Instantiated only when MODE==MUX_RR (generate).
// - Top: grant select, output register, rr_ptr register.
// TESTING
// - SEL, N=4: sel=2, in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_ch=2.
// - Backpressure: hold out_ready=0 for 3 cycles with beat registered -> out_data/out_ch stable, in_ready=0; raise out_ready -> beat drained and next beat accepted same cycle, out_valid stays 1.
// - RR, N=4: in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
// - RR sparse: in_valid=4'b1010 -> out_ch 1,3,1,3; then in_valid=4'b0001 -> out_ch 0 (wrap from ptr=0/2).
// - Reset mid-op: rst=1 one cycle while out_valid=1, rr_ptr=2 -> next cycle out_valid=0, out_data=0, out_ch=0; with in_valid=4'b1111 first grant after release is ch0.
// - SEL, N=3: sel=2'd3, in_valid=3'b111 -> in_ready=0, out_valid remains 0 for 5 cycles.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amp_mux_pkg
// Description : Shared types and helpers for the stream_mux block.
//               mux_mode_e selects between explicit-select and round-robin
//               channel selection.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package amp_mux_pkg;

  // Channel selection mode of stream_mux.
  typedef enum logic {
    MUX_SEL = 1'b0,  // channel chosen by the explicit select input
    MUX_RR  = 1'b1   // channel chosen by round-robin arbitration
  } mux_mode_e;

  // Modulo-n increment of a channel index (n-1 wraps to 0).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage : amp_mux_pkg
`default_nettype wire

// File: rtl/stream_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_if
// Description : Bundle of the N producer channels and the single consumer
//               channel of stream_mux, each with a valid/ready handshake.
// Ports       : master - producer/consumer side (drives sel, in_valid,
//                        in_data, out_ready)
//               slave  - mux side (drives in_ready, out_valid, out_data,
//                        out_ch)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0]   sel;        // explicit channel select
  logic [N-1:0]       in_valid;   // per-channel valid
  logic [N*WIDTH-1:0] in_data;    // channel i at [i*WIDTH +: WIDTH]
  logic [N-1:0]       in_ready;   // per-channel ready
  logic               out_valid;  // registered beat available
  logic [WIDTH-1:0]   out_data;   // registered beat data
  logic [SEL_W-1:0]   out_ch;     // channel that supplied out_data
  logic               out_ready;  // consumer ready

  modport master (
    output sel,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch
  );

  modport slave (
    input  sel,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch
  );

endinterface : stream_mux_if
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request found when scanning ptr, ptr+1, ... modulo N.
// Ports       : req_i     [N]      request vector
//               ptr_i     [SEL_W]  highest-priority channel this cycle
//               gnt_o     [N]      one-hot grant (all zero if no request)
//               gnt_idx_o [SEL_W]  index of the granted channel
//               gnt_any_o          a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_any_o
);

  localparam int SEL_W = $clog2(N);

  always_comb begin
    logic found;
    int   idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    found     = 1'b0;
    idx       = 0;
    // Rotate the scan start to ptr_i; the first hit in rotated order wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = SEL_W'(idx);
      end
    end
    gnt_any_o = found;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux
// Description : N-to-1 stream multiplexer with valid/ready handshake and a
//               single registered output stage. The source channel is picked
//               either by an explicit select (MUX_SEL) or by round-robin
//               arbitration (MUX_RR). Sustains one beat per cycle.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - synchronous active-high reset
//               bus  - stream_mux_if.slave: sel, in_valid, in_data, in_ready,
//                      out_valid, out_data, out_ch, out_ready
// Revision    : 1.0 - initial release
// ============================================================================
import amp_mux_pkg::*;

module stream_mux #(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter mux_mode_e MODE  = MUX_SEL
) (
  input  logic         clk,
  input  logic         rst,
  stream_mux_if.slave  bus
);

  localparam int SEL_W = $clog2(N);

  // Grant produced by whichever selection scheme is built.
  logic [N-1:0]     w_grant;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_grant_any;

  // Output stage.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;

  logic             w_adv;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  // Output stage can take a new beat when empty or being drained now.
  assign w_adv  = ~out_valid_q | bus.out_ready;
  // Grant always implies the granted channel is valid, so this is the
  // in_valid & in_ready handshake of the granted channel.
  assign w_xfer = w_grant_any & w_adv & ~rst;

  assign bus.in_ready = {N{w_adv & ~rst}} & w_grant;

  generate
    if (MODE == MUX_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
      logic             w_unused_sel;

      // Explicit select has no meaning in round-robin mode.
      assign w_unused_sel = ^bus.sel;

      rr_arbiter #(
        .N (N)
      ) u_rr_arbiter (
        .req_i     (bus.in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (w_grant),
        .gnt_idx_o (w_grant_idx),
        .gnt_any_o (w_grant_any)
      );

      // Priority moves just past the winner, and only when a beat moves.
      assign rr_ptr_d = w_xfer ? SEL_W'(wrap_inc(int'(w_grant_idx), N))
                               : rr_ptr_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= rr_ptr_d;
        end
      end
    end else begin : g_sel
      // Out-of-range select values match no channel and so grant nothing.
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
          if (int'(bus.sel) == i) begin
            w_grant[i] = bus.in_valid[i];
          end
        end
      end

      assign w_grant_idx = bus.sel;
      assign w_grant_any = |w_grant;
    end
  endgenerate

  // One-hot AND-OR mux; never indexes outside in_data for any select value.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_data = w_data | bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of the output stage. Accept takes precedence over drain so a
  // simultaneous drain+accept keeps out_valid high with no bubble; a drain
  // alone clears valid but keeps data/channel for inspection.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_data;
      out_ch_d    = w_grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule : stream_mux
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux
// Description : Directed self-checking bench for stream_mux. Three instances:
//               u_a (N=4, select mode), u_b (N=4, round-robin) and
//               u_c (N=3, WIDTH=16, select mode).
// Revision    : 1.0 - initial release
// ============================================================================
import amp_mux_pkg::*;

module tb_stream_mux;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stream_mux_if #(.WIDTH(32), .N(4)) ifa ();
  stream_mux_if #(.WIDTH(32), .N(4)) ifb ();
  stream_mux_if #(.WIDTH(16), .N(3)) ifc ();

  stream_mux #(.WIDTH(32), .N(4), .MODE(MUX_SEL)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  stream_mux #(.WIDTH(32), .N(4), .MODE(MUX_RR))  u_b (.clk(clk), .rst(rst), .bus(ifb));
  stream_mux #(.WIDTH(16), .N(3), .MODE(MUX_SEL)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // ---------------- reset ----------------
    rst           = 1'b1;
    ifa.sel       = 2'd2;
    ifa.in_valid  = 4'b0100;
    ifa.in_data   = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    ifa.out_ready = 1'b1;
    ifb.sel       = 2'd0;
    ifb.in_valid  = 4'b0000;
    ifb.in_data   = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    ifb.out_ready = 1'b1;
    ifc.sel       = 2'd0;
    ifc.in_valid  = 3'b000;
    ifc.in_data   = {16'hC002, 16'hC001, 16'hC000};
    ifc.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_a_in_ready",  64'(ifa.in_ready),  64'h0);
    chk("rst_a_out_valid", 64'(ifa.out_valid), 64'h0);
    chk("rst_a_out_data",  64'(ifa.out_data),  64'h0);
    chk("rst_a_out_ch",    64'(ifa.out_ch),    64'h0);
    chk("rst_b_out_valid", 64'(ifb.out_valid), 64'h0);
    chk("rst_c_out_valid", 64'(ifc.out_valid), 64'h0);

    // ---------------- SEL basic: sel=2 ----------------
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("sel2_in_ready", 64'(ifa.in_ready), 64'h4);
    tick();
    chk("sel2_out_valid", 64'(ifa.out_valid), 64'h1);
    chk("sel2_out_data",  64'(ifa.out_data),  64'hDEAD_BEEF);
    chk("sel2_out_ch",    64'(ifa.out_ch),    64'h2);

    // ---------------- backpressure ----------------
    @(negedge clk);
    ifa.out_ready = 1'b0;
    ifa.in_data   = {32'h4444_4444, 32'h1234_5678, 32'h2222_2222, 32'h1111_1111};
    #1;
    chk("bp_in_ready_pre", 64'(ifa.in_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_out_valid", 64'(ifa.out_valid), 64'h1);
      chk("bp_out_data",  64'(ifa.out_data),  64'hDEAD_BEEF);
      chk("bp_out_ch",    64'(ifa.out_ch),    64'h2);
      chk("bp_in_ready",  64'(ifa.in_ready),  64'h0);
    end
    @(negedge clk);
    ifa.out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 64'(ifa.in_ready), 64'h4);
    tick();
    chk("drain_out_valid", 64'(ifa.out_valid), 64'h1);
    chk("drain_out_data",  64'(ifa.out_data),  64'h1234_5678);
    chk("drain_out_ch",    64'(ifa.out_ch),    64'h2);

    // ---------------- select change ----------------
    @(negedge clk);
    ifa.sel      = 2'd1;
    ifa.in_valid = 4'b0010;
    #1;
    chk("sel1_in_ready", 64'(ifa.in_ready), 64'h2);
    tick();
    chk("sel1_out_data", 64'(ifa.out_data), 64'h2222_2222);
    chk("sel1_out_ch",   64'(ifa.out_ch),   64'h1);
    // select points at an idle channel: no grant, beat drains, data held
    @(negedge clk);
    ifa.sel = 2'd0;
    #1;
    chk("selmiss_in_ready", 64'(ifa.in_ready), 64'h0);
    tick();
    chk("selmiss_out_valid", 64'(ifa.out_valid), 64'h0);
    chk("selmiss_out_data",  64'(ifa.out_data),  64'h2222_2222);
    chk("selmiss_out_ch",    64'(ifa.out_ch),    64'h1);
    @(negedge clk);
    ifa.in_valid = 4'b0000;

    // ---------------- RR all valid ----------------
    ifb.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_full_out_valid", 64'(ifb.out_valid), 64'h1);
      chk("rr_full_out_ch",    64'(ifb.out_ch),    64'(k % 4));
      chk("rr_full_out_data",  64'(ifb.out_data),  64'(32'h100 + (k % 4)));
    end

    // ---------------- reset mid-operation (rr_ptr=2) ----------------
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rrrst_in_ready_rst", 64'(ifb.in_ready), 64'h0);
    tick();
    chk("rrrst_out_valid", 64'(ifb.out_valid), 64'h0);
    chk("rrrst_out_data",  64'(ifb.out_data),  64'h0);
    chk("rrrst_out_ch",    64'(ifb.out_ch),    64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rrrst_in_ready", 64'(ifb.in_ready), 64'h1);
    tick();
    chk("rrrst_first_ch",   64'(ifb.out_ch),   64'h0);
    chk("rrrst_first_data", 64'(ifb.out_data), 64'h100);

    // ---------------- RR sparse (ptr=1) ----------------
    @(negedge clk);
    ifb.in_valid = 4'b1010;
    tick();
    chk("rr_sparse0_ch", 64'(ifb.out_ch), 64'h1);
    tick();
    chk("rr_sparse1_ch", 64'(ifb.out_ch), 64'h3);
    tick();
    chk("rr_sparse2_ch", 64'(ifb.out_ch), 64'h1);
    tick();
    chk("rr_sparse3_ch",   64'(ifb.out_ch),   64'h3);
    chk("rr_sparse3_data", 64'(ifb.out_data), 64'h103);
    // pointer wrapped 3 -> 0; only ch0 requesting
    @(negedge clk);
    ifb.in_valid = 4'b0001;
    tick();
    chk("rr_wrap_ch",    64'(ifb.out_ch),    64'h0);
    chk("rr_wrap_valid", 64'(ifb.out_valid), 64'h1);
    @(negedge clk);
    ifb.in_valid = 4'b0000;
    tick();
    chk("rr_idle_valid", 64'(ifb.out_valid), 64'h0);

    // ---------------- SEL N=3, out-of-range select ----------------
    @(negedge clk);
    ifc.sel      = 2'd3;
    ifc.in_valid = 3'b111;
    #1;
    chk("n3_oob_in_ready_pre", 64'(ifc.in_ready), 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("n3_oob_out_valid", 64'(ifc.out_valid), 64'h0);
      chk("n3_oob_in_ready",  64'(ifc.in_ready),  64'h0);
    end
    @(negedge clk);
    ifc.sel = 2'd2;
    #1;
    chk("n3_sel2_in_ready", 64'(ifc.in_ready), 64'h4);
    tick();
    chk("n3_sel2_out_valid", 64'(ifc.out_valid), 64'h1);
    chk("n3_sel2_out_data",  64'(ifc.out_data),  64'hC002);
    chk("n3_sel2_out_ch",    64'(ifc.out_ch),    64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_mux
`default_nettype wire
